// File: rtl/ami_channel_app_arbiter.sv
// Shares one memory channel among several apps using round-robin with a burst quantum.
// Also tracks outstanding reads per app and holds the chosen request in a one-entry output register.
package ami_pkg;

  typedef struct packed {
    logic        valid;
    logic        isWrite;
    logic [7:0]  srcApp;
    logic [47:0] addr;
    logic [63:0] data;
    logic [7:0]  size;
  } AMIReq;

endpackage

module ami_channel_app_arbiter
  import ami_pkg::*;
#(
  parameter int NUM_APPS        = 4,
  parameter int QUANTUM         = 4,
  parameter int MAX_OUTSTANDING = 16,
  localparam int APP_BITS       = $clog2(NUM_APPS),
  localparam int CNT_BITS       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_APPS-1:0] app_enable,
  input  AMIReq               ami_mem_req_in [NUM_APPS],
  output logic [NUM_APPS-1:0] ami_mem_req_grant_out,
  output AMIReq               ami_mem_req_out,
  input  logic                ami_mem_req_grant_in,
  input  logic                rd_resp_valid,
  input  logic [APP_BITS-1:0] rd_resp_app,
  output logic [APP_BITS-1:0] owner_app,
  output logic                outstanding_err
);

  localparam int QCNT_BITS = $clog2(QUANTUM + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state, state_nxt;
  logic [APP_BITS-1:0]  owner, owner_nxt;
  logic [QCNT_BITS-1:0] burst_cnt, burst_cnt_nxt;
  logic [CNT_BITS-1:0]  outstanding [NUM_APPS];
  AMIReq                out_req;

  logic [NUM_APPS-1:0]  eligible;
  logic                 load_ok;
  logic                 pick_valid;
  logic [APP_BITS-1:0]  pick;
  logic [NUM_APPS-1:0]  rd_inc;
  logic [NUM_APPS-1:0]  rd_dec;
  logic                 resp_err;

  assign load_ok         = !out_req.valid || ami_mem_req_grant_in;
  assign ami_mem_req_out = out_req;
  assign owner_app       = owner;
  assign ami_mem_req_grant_out = pick_valid ? (NUM_APPS'(1) << pick) : '0;

  // Writes are never throttled; reads stop once the app has MAX_OUTSTANDING in flight.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_APPS; i++) begin
      eligible[i] = app_enable[i] && ami_mem_req_in[i].valid &&
                    (ami_mem_req_in[i].isWrite ||
                     outstanding[i] < CNT_BITS'(MAX_OUTSTANDING));
    end
  end

  // Owner keeps the channel while under quantum; otherwise scan from owner+1 with owner last.
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick       = owner;
    if (load_ok && !rst) begin
      if (state == BURST && eligible[owner] && burst_cnt < QCNT_BITS'(QUANTUM)) begin
        pick_valid = 1'b1;
        pick       = owner;
      end else begin
        for (int k = NUM_APPS; k >= 1; k--) begin
          idx = (int'(owner) + k) % NUM_APPS;
          if (eligible[idx]) begin
            pick_valid = 1'b1;
            pick       = APP_BITS'(idx);
          end
        end
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    burst_cnt_nxt = burst_cnt;
    if (pick_valid) begin
      state_nxt = BURST;
      if (state == BURST && pick == owner) begin
        if (burst_cnt < QCNT_BITS'(QUANTUM))
          burst_cnt_nxt = burst_cnt + QCNT_BITS'(1);
      end else begin
        owner_nxt     = pick;
        burst_cnt_nxt = QCNT_BITS'(1);
      end
    end else if (load_ok && state == BURST && !ami_mem_req_in[owner].valid) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= APP_BITS'(NUM_APPS - 1);
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Request fields are forwarded untouched; only valid is cleared on a drain with no refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_req <= '0;
    end else if (pick_valid) begin
      out_req <= ami_mem_req_in[pick];
    end else if (out_req.valid && ami_mem_req_grant_in) begin
      out_req.valid <= 1'b0;
    end
  end

  // A read grant and a response for the same app in one cycle cancel each other.
  always_comb begin
    rd_inc   = '0;
    rd_dec   = '0;
    resp_err = 1'b0;
    for (int i = 0; i < NUM_APPS; i++) begin
      rd_inc[i] = pick_valid && (int'(pick) == i) && !ami_mem_req_in[i].isWrite;
      rd_dec[i] = rd_resp_valid && (int'(rd_resp_app) == i);
      if (rd_dec[i] && !rd_inc[i] && outstanding[i] == '0)
        resp_err = 1'b1;
    end
    if (rd_resp_valid && int'(rd_resp_app) >= NUM_APPS)
      resp_err = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_APPS; i++)
        outstanding[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_APPS; i++) begin
        if (rd_inc[i] && !rd_dec[i])
          outstanding[i] <= outstanding[i] + CNT_BITS'(1);
        else if (rd_dec[i] && !rd_inc[i] && outstanding[i] != '0)
          outstanding[i] <= outstanding[i] - CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      outstanding_err <= 1'b0;
    else if (resp_err)
      outstanding_err <= 1'b1;
  end

endmodule
